// File: rtl/jtag_tap_pkg.sv
// TAP state encoding, instruction opcodes and default IR width shared by jtag_tap and its FSM.
package jtag_tap_pkg;

  localparam int IR_WIDTH_DEF = 5;

  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR        = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR        = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_e;

  localparam logic [4:0] OP_IDCODE = 5'h01;
  localparam logic [4:0] OP_BYPASS = 5'h1F;
  localparam logic [4:0] OP_DBGREG = 5'h10;

  typedef enum logic [1:0] {
    SEL_BYPASS,
    SEL_IDCODE,
    SEL_DBGREG
  } dr_sel_e;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller state machine, advanced only on a tck rise event.
// Latency: state moves on the clk edge where rise is high; reset forces Test-Logic-Reset next edge.
// Backpressure: none; rise must already be a single-clk event.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rise,
  input  logic       tms,
  output logic [3:0] tap_state
);

  tap_state_e state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= TEST_LOGIC_RESET;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (rise) begin
      case (state)
        TEST_LOGIC_RESET: state_nxt = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
        RUN_TEST_IDLE:    state_nxt = tms ? SELECT_DR        : RUN_TEST_IDLE;
        SELECT_DR:        state_nxt = tms ? SELECT_IR        : CAPTURE_DR;
        CAPTURE_DR:       state_nxt = tms ? EXIT1_DR         : SHIFT_DR;
        SHIFT_DR:         state_nxt = tms ? EXIT1_DR         : SHIFT_DR;
        EXIT1_DR:         state_nxt = tms ? UPDATE_DR        : PAUSE_DR;
        PAUSE_DR:         state_nxt = tms ? EXIT2_DR         : PAUSE_DR;
        EXIT2_DR:         state_nxt = tms ? UPDATE_DR        : SHIFT_DR;
        UPDATE_DR:        state_nxt = tms ? SELECT_DR        : RUN_TEST_IDLE;
        SELECT_IR:        state_nxt = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
        CAPTURE_IR:       state_nxt = tms ? EXIT1_IR         : SHIFT_IR;
        SHIFT_IR:         state_nxt = tms ? EXIT1_IR         : SHIFT_IR;
        EXIT1_IR:         state_nxt = tms ? UPDATE_IR        : PAUSE_IR;
        PAUSE_IR:         state_nxt = tms ? EXIT2_IR         : PAUSE_IR;
        EXIT2_IR:         state_nxt = tms ? UPDATE_IR        : SHIFT_IR;
        UPDATE_IR:        state_nxt = tms ? SELECT_DR        : RUN_TEST_IDLE;
        default:          state_nxt = TEST_LOGIC_RESET;
      endcase
    end
  end

  assign tap_state = state;

endmodule

// File: rtl/jtag_tap.sv
// JTAG TAP oversampled on clk: IR, BYPASS, IDCODE and (with JTAG_TAP_DBGREG_EN) a debug data register.
// Latency: pin edge -> rise/fall event 3 clk, register action on the 4th clk edge.
// Backpressure: none; tck high and low phases must each last at least 3 clk.
module jtag_tap
  import jtag_tap_pkg::*;
#(
  parameter int          IR_WIDTH  = IR_WIDTH_DEF,
  parameter logic [31:0] IDCODE    = 32'h0C0F_FEE1,
  parameter int          DBG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tck,
  input  logic                 tms,
  input  logic                 tdi,
  input  logic                 trst,
  output logic                 tdo,
  output logic [3:0]           tap_state,
  output logic [IR_WIDTH-1:0]  ir_out,
  output logic                 dbg_wr,
  output logic [DBG_WIDTH-1:0] dbg_wdata,
  input  logic [DBG_WIDTH-1:0] dbg_rdata
);

  logic       reset_all;
  logic [1:0] tck_sync, tms_sync, tdi_sync;
  logic       tck_prev, tms_q, tdi_q;
  logic       tck_rise, tck_fall;

  assign reset_all = rst | trst;

  // tms/tdi get the same extra stage as tck so they stay aligned with the edge events.
  always_ff @(posedge clk) begin
    if (reset_all) begin
      tck_sync <= '0;
      tms_sync <= '0;
      tdi_sync <= '0;
      tck_prev <= 1'b0;
      tms_q    <= 1'b0;
      tdi_q    <= 1'b0;
      tck_rise <= 1'b0;
      tck_fall <= 1'b0;
    end else begin
      tck_sync <= {tck_sync[0], tck};
      tms_sync <= {tms_sync[0], tms};
      tdi_sync <= {tdi_sync[0], tdi};
      tck_prev <= tck_sync[1];
      tms_q    <= tms_sync[1];
      tdi_q    <= tdi_sync[1];
      tck_rise <= tck_sync[1] & ~tck_prev;
      tck_fall <= ~tck_sync[1] & tck_prev;
    end
  end

  jtag_tap_fsm u_fsm (
    .clk       (clk),
    .rst       (reset_all),
    .rise      (tck_rise),
    .tms       (tms_q),
    .tap_state (tap_state)
  );

  tap_state_e state;
  assign state = tap_state_e'(tap_state);

  dr_sel_e dr_sel;

  always_comb begin
    dr_sel = SEL_BYPASS;
    if (ir_out == IR_WIDTH'(OP_BYPASS)) begin
      dr_sel = SEL_BYPASS;
    end else if (ir_out == IR_WIDTH'(OP_IDCODE)) begin
      dr_sel = SEL_IDCODE;
    end
`ifdef JTAG_TAP_DBGREG_EN
    else if (ir_out == IR_WIDTH'(OP_DBGREG)) begin
      dr_sel = SEL_DBGREG;
    end
`endif
  end

  logic [IR_WIDTH-1:0] ir_sr;
  logic [31:0]         id_sr;
  logic                bypass_sr;
  logic                dbg_lsb;
  logic                dr_lsb;

  always_comb begin
    dr_lsb = bypass_sr;
    case (dr_sel)
      SEL_IDCODE: dr_lsb = id_sr[0];
      SEL_DBGREG: dr_lsb = dbg_lsb;
      default:    dr_lsb = bypass_sr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_all) begin
      ir_sr     <= '0;
      id_sr     <= '0;
      bypass_sr <= 1'b0;
      ir_out    <= IR_WIDTH'(OP_IDCODE);
      tdo       <= 1'b0;
    end else begin
      if (tck_rise) begin
        case (state)
          CAPTURE_IR: ir_sr <= IR_WIDTH'(2'b01);
          SHIFT_IR:   ir_sr <= {tdi_q, ir_sr[IR_WIDTH-1:1]};
          CAPTURE_DR: begin
            if (dr_sel == SEL_IDCODE) id_sr <= IDCODE;
            if (dr_sel == SEL_BYPASS) bypass_sr <= 1'b0;
          end
          SHIFT_DR: begin
            if (dr_sel == SEL_IDCODE) id_sr <= {tdi_q, id_sr[31:1]};
            if (dr_sel == SEL_BYPASS) bypass_sr <= tdi_q;
          end
          default: ;
        endcase
      end

      if (state == TEST_LOGIC_RESET) begin
        ir_out <= IR_WIDTH'(OP_IDCODE);
      end else if (tck_fall && state == UPDATE_IR) begin
        ir_out <= ir_sr;
      end

      // tdo only moves on falling tck so the host samples a stable bit on the next rise.
      if (tck_fall) begin
        case (state)
          SHIFT_IR: tdo <= ir_sr[0];
          SHIFT_DR: tdo <= dr_lsb;
          default:  tdo <= 1'b0;
        endcase
      end
    end
  end

`ifdef JTAG_TAP_DBGREG_EN
  logic [DBG_WIDTH-1:0] dbg_sr;

  always_ff @(posedge clk) begin
    if (reset_all) begin
      dbg_sr    <= '0;
      dbg_wr    <= 1'b0;
      dbg_wdata <= '0;
    end else begin
      dbg_wr <= 1'b0;
      if (tck_rise && dr_sel == SEL_DBGREG) begin
        if (state == CAPTURE_DR) begin
          dbg_sr <= dbg_rdata;
        end else if (state == SHIFT_DR) begin
          dbg_sr <= {tdi_q, dbg_sr[DBG_WIDTH-1:1]};
        end
      end
      if (tck_fall && state == UPDATE_DR && dr_sel == SEL_DBGREG) begin
        dbg_wr    <= 1'b1;
        dbg_wdata <= dbg_sr;
      end
    end
  end

  assign dbg_lsb = dbg_sr[0];
`else
  logic dbg_rdata_unused;

  assign dbg_wr           = 1'b0;
  assign dbg_wdata        = '0;
  assign dbg_lsb          = 1'b0;
  assign dbg_rdata_unused = ^dbg_rdata;
`endif

endmodule

// File: tb/tb_jtag_tap.sv
// Randomized bench for jtag_tap against a queue-based TAP reference model; honours JTAG_TAP_DBGREG_EN.
module tb_jtag_tap;
  import jtag_tap_pkg::*;

  localparam int          IRW = 5;
  localparam int          DW  = 32;
  localparam logic [31:0] ID  = 32'h0C0F_FEE1;
`ifdef JTAG_TAP_DBGREG_EN
  localparam bit          DBG_EN = 1'b1;
`else
  localparam bit          DBG_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           tck = 1'b0;
  logic           tms = 1'b0;
  logic           tdi = 1'b0;
  logic           trst = 1'b0;
  logic [DW-1:0]  dbg_rdata = '0;
  logic           tdo, dbg_wr;
  logic [3:0]     tap_state;
  logic [IRW-1:0] ir_out;
  logic [DW-1:0]  dbg_wdata;

  jtag_tap #(.IR_WIDTH(IRW), .IDCODE(ID), .DBG_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .trst      (trst),
    .tdo       (tdo),
    .tap_state (tap_state),
    .ir_out    (ir_out),
    .dbg_wr    (dbg_wr),
    .dbg_wdata (dbg_wdata),
    .dbg_rdata (dbg_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: IEEE transition table plus shift registers held as bit queues (LSB at front).
  tap_state_e     nxt0 [16];
  tap_state_e     nxt1 [16];
  tap_state_e     m_state;
  logic           m_ir_q [$];
  logic           m_dr_q [$];
  logic [IRW-1:0] m_ir_out;
  logic           m_tdo;
  logic [DW-1:0]  m_wdata;
  int             m_wr_cnt = 0;

  int wr_pulses = 0;
  int wr_run = 0;
  int wr_maxrun = 0;

  always @(negedge clk) begin
    if (dbg_wr === 1'b1) begin
      if (wr_run == 0) wr_pulses++;
      wr_run++;
      if (wr_run > wr_maxrun) wr_maxrun = wr_run;
    end else begin
      wr_run = 0;
    end
  end

  task automatic arc(input tap_state_e s, input tap_state_e n0, input tap_state_e n1);
    nxt0[s] = n0;
    nxt1[s] = n1;
  endtask

  task automatic init_table();
    arc(TEST_LOGIC_RESET, RUN_TEST_IDLE, TEST_LOGIC_RESET);
    arc(RUN_TEST_IDLE,    RUN_TEST_IDLE, SELECT_DR);
    arc(SELECT_DR,        CAPTURE_DR,    SELECT_IR);
    arc(CAPTURE_DR,       SHIFT_DR,      EXIT1_DR);
    arc(SHIFT_DR,         SHIFT_DR,      EXIT1_DR);
    arc(EXIT1_DR,         PAUSE_DR,      UPDATE_DR);
    arc(PAUSE_DR,         PAUSE_DR,      EXIT2_DR);
    arc(EXIT2_DR,         SHIFT_DR,      UPDATE_DR);
    arc(UPDATE_DR,        RUN_TEST_IDLE, SELECT_DR);
    arc(SELECT_IR,        CAPTURE_IR,    TEST_LOGIC_RESET);
    arc(CAPTURE_IR,       SHIFT_IR,      EXIT1_IR);
    arc(SHIFT_IR,         SHIFT_IR,      EXIT1_IR);
    arc(EXIT1_IR,         PAUSE_IR,      UPDATE_IR);
    arc(PAUSE_IR,         PAUSE_IR,      EXIT2_IR);
    arc(EXIT2_IR,         SHIFT_IR,      UPDATE_IR);
    arc(UPDATE_IR,        RUN_TEST_IDLE, SELECT_DR);
  endtask

  task automatic model_reset();
    m_state  = TEST_LOGIC_RESET;
    m_ir_out = IRW'(1);
    m_tdo    = 1'b0;
    m_wdata  = '0;
    m_ir_q   = {};
    m_dr_q   = {};
  endtask

  // 0 = bypass, 1 = idcode, 2 = debug register
  function automatic int m_sel();
    if (m_ir_out == IRW'(1)) return 1;
    if (DBG_EN && m_ir_out == IRW'(5'h10)) return 2;
    return 0;
  endfunction

  task automatic model_rise(input logic t, input logic d);
    logic [31:0] idv;
    logic [DW-1:0] rdv;
    idv = ID;
    rdv = dbg_rdata;
    case (m_state)
      CAPTURE_IR: begin
        m_ir_q = {};
        m_ir_q.push_back(1'b1);
        for (int i = 1; i < IRW; i++) m_ir_q.push_back(1'b0);
      end
      SHIFT_IR: begin
        void'(m_ir_q.pop_front());
        m_ir_q.push_back(d);
      end
      CAPTURE_DR: begin
        m_dr_q = {};
        case (m_sel())
          1:       for (int i = 0; i < 32; i++) m_dr_q.push_back(idv[i]);
          2:       for (int i = 0; i < DW; i++) m_dr_q.push_back(rdv[i]);
          default: m_dr_q.push_back(1'b0);
        endcase
      end
      SHIFT_DR: begin
        void'(m_dr_q.pop_front());
        m_dr_q.push_back(d);
      end
      default: ;
    endcase
    m_state = t ? nxt1[m_state] : nxt0[m_state];
    if (m_state == TEST_LOGIC_RESET) m_ir_out = IRW'(1);
  endtask

  task automatic model_fall();
    if (m_state == UPDATE_IR) begin
      for (int i = 0; i < IRW; i++) m_ir_out[i] = m_ir_q[i];
    end
    if (m_state == UPDATE_DR && m_sel() == 2) begin
      for (int i = 0; i < DW; i++) m_wdata[i] = m_dr_q[i];
      m_wr_cnt++;
    end
    if (m_state == SHIFT_IR)      m_tdo = m_ir_q[0];
    else if (m_state == SHIFT_DR) m_tdo = m_dr_q[0];
    else                          m_tdo = 1'b0;
  endtask

  // One full tck period with 6-clk phases; the model steps once each phase has settled.
  task automatic tck_cycle(input logic t, input logic d);
    @(negedge clk);
    tms = t;
    tdi = d;
    repeat (3) @(negedge clk);
    tck = 1'b1;
    repeat (6) @(negedge clk);
    model_rise(t, d);
    tck = 1'b0;
    repeat (6) @(negedge clk);
    model_fall();
  endtask

  // From Test-Logic-Reset or Run-Test/Idle; ends in Run-Test/Idle.
  task automatic scan_ir(input logic [IRW-1:0] val, output logic [IRW-1:0] obs,
                         output logic [IRW-1:0] exp);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
    obs[0] = tdo;
    exp[0] = m_tdo;
    for (int i = 0; i < IRW; i++) begin
      tck_cycle(i == IRW - 1, val[i]);
      if (i < IRW - 1) begin
        obs[i+1] = tdo;
        exp[i+1] = m_tdo;
      end
    end
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
  endtask

  task automatic scan_dr(input logic [31:0] data, input int n, output logic [31:0] obs,
                         output logic [31:0] exp);
    obs = '0;
    exp = '0;
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
    obs[0] = tdo;
    exp[0] = m_tdo;
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, data[i]);
      if (i < n - 1) begin
        obs[i+1] = tdo;
        exp[i+1] = m_tdo;
      end
    end
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (tap_state !== TEST_LOGIC_RESET) begin errors++; $display("FAIL reset_state: got %0h want %0h", tap_state, TEST_LOGIC_RESET); end
    checks++; if (ir_out !== 5'h01) begin errors++; $display("FAIL reset_ir_out: got %0h want 01", ir_out); end
    checks++; if (tdo !== 1'b0) begin errors++; $display("FAIL reset_tdo: got %b want 0", tdo); end
    checks++; if (dbg_wr !== 1'b0) begin errors++; $display("FAIL reset_dbg_wr: got %b want 0", dbg_wr); end
    checks++; if (dbg_wdata !== '0) begin errors++; $display("FAIL reset_dbg_wdata: got %0h want 0", dbg_wdata); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_sync_latency();
    @(negedge clk);
    tms = 1'b0;
    tdi = 1'b0;
    repeat (4) @(negedge clk);
    tck = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tap_state !== TEST_LOGIC_RESET) begin errors++; $display("FAIL sync_early: got %0h want %0h", tap_state, TEST_LOGIC_RESET); end
    @(posedge clk);
    #1;
    checks++; if (tap_state !== RUN_TEST_IDLE) begin errors++; $display("FAIL sync_on_time: got %0h want %0h", tap_state, RUN_TEST_IDLE); end
    repeat (4) @(negedge clk);
    model_rise(1'b0, 1'b0);
    tck = 1'b0;
    repeat (6) @(negedge clk);
    model_fall();
  endtask

  task automatic test_idcode();
    logic [31:0] obs, exp;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    scan_dr($urandom, 32, obs, exp);
    checks++; if (obs !== 32'h0C0F_FEE1) begin errors++; $display("FAIL idcode_word: got %h want 0c0ffee1", obs); end
    checks++; if (obs !== exp) begin errors++; $display("FAIL idcode_model: got %h want %h", obs, exp); end
  endtask

  task automatic test_ir_capture();
    logic [IRW-1:0] obs, exp;
    scan_ir(5'h00, obs, exp);
    checks++; if (obs !== 5'b00001) begin errors++; $display("FAIL ir_capture: got %b want 00001 (LSB first)", obs); end
    checks++; if (obs !== exp) begin errors++; $display("FAIL ir_capture_model: got %b want %b", obs, exp); end
    checks++; if (ir_out !== 5'h00) begin errors++; $display("FAIL ir_update: got %0h want 00", ir_out); end
  endtask

  task automatic test_bypass();
    logic [IRW-1:0] io, ie;
    logic [31:0] obs, exp, data, want;
    scan_ir(5'h1F, io, ie);
    checks++; if (ir_out !== 5'h1F) begin errors++; $display("FAIL bypass_ir: got %0h want 1f", ir_out); end
    scan_dr(32'h0000_00A5, 9, obs, exp);
    checks++; if (obs[8:0] !== 9'h14A) begin errors++; $display("FAIL bypass_a5: got %h want 14a", obs[8:0]); end
    data = {16'h0, 16'($urandom)};
    want = (data << 1) & 32'h0000_FFFF;
    scan_dr(data, 16, obs, exp);
    checks++; if (obs !== want) begin errors++; $display("FAIL bypass_rand: got %h want %h", obs, want); end
    checks++; if (obs !== exp) begin errors++; $display("FAIL bypass_model: got %h want %h", obs, exp); end
  endtask

  task automatic test_dbgreg();
    logic [IRW-1:0] io, ie;
    logic [31:0] obs, exp, beef, want_tdo, want_wdata;
    int base, want_wr;
    beef = 32'hDEAD_BEEF;
`ifdef JTAG_TAP_DBGREG_EN
    want_tdo   = 32'h1234_5678;
    want_wdata = beef;
    want_wr    = 1;
`else
    want_tdo   = {beef[30:0], 1'b0};
    want_wdata = 32'h0;
    want_wr    = 0;
`endif
    dbg_rdata = 32'h1234_5678;
    scan_ir(5'h10, io, ie);
    base = wr_pulses;
    scan_dr(beef, 32, obs, exp);
    checks++; if (obs !== want_tdo) begin errors++; $display("FAIL dbg_tdo: got %h want %h", obs, want_tdo); end
    checks++; if (obs !== exp) begin errors++; $display("FAIL dbg_model: got %h want %h", obs, exp); end
    checks++; if (wr_pulses - base !== want_wr) begin errors++; $display("FAIL dbg_wr_count: got %0d want %0d", wr_pulses - base, want_wr); end
    checks++; if (wr_maxrun !== want_wr) begin errors++; $display("FAIL dbg_wr_width: got %0d clk want %0d", wr_maxrun, want_wr); end
    checks++; if (dbg_wdata !== want_wdata) begin errors++; $display("FAIL dbg_wdata: got %h want %h", dbg_wdata, want_wdata); end
  endtask

  task automatic test_trst_midscan();
    logic [IRW-1:0] io, ie;
    int base;
    scan_ir(5'h10, io, ie);
    base = wr_pulses;
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tck_cycle(1'b0, 1'($urandom));
    @(negedge clk);
    trst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (tap_state !== TEST_LOGIC_RESET) begin errors++; $display("FAIL trst_state: got %0h want %0h", tap_state, TEST_LOGIC_RESET); end
    checks++; if (ir_out !== 5'h01) begin errors++; $display("FAIL trst_ir_out: got %0h want 01", ir_out); end
    checks++; if (tdo !== 1'b0) begin errors++; $display("FAIL trst_tdo: got %b want 0", tdo); end
    checks++; if (dbg_wdata !== '0) begin errors++; $display("FAIL trst_wdata: got %h want 0", dbg_wdata); end
    @(negedge clk);
    trst = 1'b0;
    model_reset();
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    checks++; if (wr_pulses !== base) begin errors++; $display("FAIL trst_no_wr: got %0d pulses want %0d", wr_pulses, base); end
    checks++; if (tap_state !== RUN_TEST_IDLE) begin errors++; $display("FAIL trst_resume: got %0h want %0h", tap_state, RUN_TEST_IDLE); end
  endtask

  task automatic test_tlr_from_any();
    for (int it = 0; it < 8; it++) begin
      int n;
      n = $urandom_range(2, 25);
      for (int k = 0; k < n; k++) begin
        dbg_rdata = $urandom;
        tck_cycle(1'($urandom), 1'($urandom));
      end
      for (int k = 0; k < 5; k++) tck_cycle(1'b1, 1'($urandom));
      checks++; if (tap_state !== TEST_LOGIC_RESET) begin errors++; $display("FAIL tlr_state[%0d]: got %0h want %0h", it, tap_state, TEST_LOGIC_RESET); end
      checks++; if (ir_out !== 5'h01) begin errors++; $display("FAIL tlr_ir_out[%0d]: got %0h want 01", it, ir_out); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      dbg_rdata = $urandom;
      tck_cycle(1'($urandom), 1'($urandom));
      checks++; if (tap_state !== m_state) begin errors++; $display("FAIL rand_state[%0d]: got %0h want %0h", k, tap_state, m_state); end
      checks++; if (tdo !== m_tdo) begin errors++; $display("FAIL rand_tdo[%0d]: got %b want %b", k, tdo, m_tdo); end
      checks++; if (ir_out !== m_ir_out) begin errors++; $display("FAIL rand_ir_out[%0d]: got %0h want %0h", k, ir_out, m_ir_out); end
    end
    checks++; if (wr_pulses !== m_wr_cnt) begin errors++; $display("FAIL rand_wr_count: got %0d want %0d", wr_pulses, m_wr_cnt); end
    checks++; if (dbg_wdata !== m_wdata) begin errors++; $display("FAIL rand_wdata: got %h want %h", dbg_wdata, m_wdata); end
  endtask

  initial begin
    init_table();
    model_reset();
    test_reset();
    test_sync_latency();
    test_idcode();
    test_ir_capture();
    test_bypass();
    test_dbgreg();
    test_trst_midscan();
    test_tlr_from_any();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jtag_tap.md
JTAG_TAP -- requirements
Module: jtag_tap

Interface
- REQ-001 Param IR_WIDTH, 5, instruction register width (>=2).
- REQ-002 Param IDCODE, 32'h0C0F_FEE1, device ID; bit0 SHALL be 1.
- REQ-003 Param DBG_WIDTH, 32, debug data register width.
- REQ-004 clk  in  1  system clock; the only clock.
- REQ-005 rst  in  1  reset, synchronous, active-high.
- REQ-006 tck  in  1  JTAG clock, asynchronous, sampled on clk.
- REQ-007 tms  in  1  JTAG mode select.
- REQ-008 tdi  in  1  JTAG data in.
- REQ-009 trst  in  1  JTAG test reset, active-high, sampled on clk.
- REQ-010 tdo  out  1  JTAG data out.
- REQ-011 tap_state  out  4  current TAP state encoding.
- REQ-012 ir_out  out  IR_WIDTH  active instruction.
- REQ-013 dbg_wr  out  1  one-clk pulse on DBGREG update.
- REQ-014 dbg_wdata  out  DBG_WIDTH  value shifted into DBGREG, held until next update.
- REQ-015 dbg_rdata  in  DBG_WIDTH  value captured into DBGREG on Capture-DR.

Function
- REQ-016 tck, tms and tdi SHALL each pass a 2-flop synchronizer; a rise/fall event SHALL be flagged in the single clk cycle after a synchronized tck transition (3 clk from the pin).
- REQ-017 tck high and low phases SHALL each be >=3 clk; faster tck is unsupported and its behaviour is undefined.
- REQ-018 FSM: the 16 IEEE 1149.1 TAP states; the transition SHALL occur only on a rise event, using synchronized tms.
- REQ-019 Five consecutive rise events with tms=1 SHALL reach Test-Logic-Reset from any state.
- REQ-020 Capture-IR, on rise event: IR shift register loads {0..0,2'b01}.
- REQ-021 Shift-IR/Shift-DR, on rise event: the selected shift register shifts right, with tdi entering at the MSB.
- REQ-022 Update-IR, on fall event: ir_out loads the IR shift register.
- REQ-023 Instructions: IDCODE=1; BYPASS=all-ones; DBGREG=5'h10. Every other opcode SHALL select BYPASS.
- REQ-024 Capture-DR data register: IDCODE loads IDCODE; BYPASS loads 1'b0; DBGREG loads dbg_rdata.
- REQ-025 Update-DR with DBGREG active, on fall event: dbg_wdata loads the shift register and dbg_wr pulses high for exactly 1 clk.
- REQ-026 tdo SHALL update only on a fall event, to the LSB of the active shift register while in Shift-IR/Shift-DR, else 0.
- REQ-027 A simultaneous trst and rise event SHALL resolve as trst.
- REQ-028 Test-Logic-Reset state: ir_out SHALL reset to IDCODE.

Reset
- REQ-029 rst or trst SHALL, on the next clk edge, force Test-Logic-Reset, ir_out=IDCODE, tdo=0, dbg_wr=0, dbg_wdata=0, shift registers=0 and synchronizers=0.
- REQ-030 Reset mid-scan SHALL abandon the scan with no update and no dbg_wr.

Configuration
- REQ-031 With JTAG_TAP_DBGREG_EN defined: DBGREG, dbg_wr, dbg_wdata and dbg_rdata behave as above.
- REQ-032 Without JTAG_TAP_DBGREG_EN: opcode 5'h10 decodes as BYPASS, dbg_wr and dbg_wdata are tied to 0, dbg_rdata is ignored, and the ports remain present.

Structure
- REQ-033 Package jtag_tap_pkg SHALL hold the TAP state enum, the instruction opcode constants and the IR_WIDTH default.
- REQ-034 Sub-module jtag_tap_fsm: next-state logic and state register, driven by the rise event and tms.

Verification
- REQ-035 From an arbitrary state, 5 rises with tms=1 -> tap_state=Test-Logic-Reset, ir_out=5'h01.
- REQ-036 After reset, go to Shift-DR and shift 32 bits -> tdo emits 32'h0C0F_FEE1 LSB first.
- REQ-037 Load IR=5'h1F, shift 8'hA5 into DR -> tdo = 0 then A5 bits, delayed by one tck.
- REQ-038 Shift-IR with tdi=0 for 5 bits -> tdo emits 1,0,0,0,0.
- REQ-039 DBGREG with dbg_rdata=32'h1234_5678, shift in 32'hDEAD_BEEF -> tdo emits 32'h1234_5678; at Update-DR dbg_wr is high for 1 clk and dbg_wdata=32'hDEAD_BEEF.
- REQ-040 trst pulsed at Shift-DR bit 10 -> Test-Logic-Reset on the next clk, dbg_wr never asserts, ir_out=5'h01.
